// File: rtl/sfr_mon_pkg.sv
// Shared types for the SFR bus capture engine: transaction record and its builder.
package sfr_mon_pkg;

   localparam int unsigned SFR_ADDR_W = 8;
   localparam int unsigned SFR_DATA_W = 8;

   typedef struct packed {
      logic                  err;
      logic                  we;
      logic [SFR_ADDR_W-1:0] addr;
      logic [SFR_DATA_W-1:0] wdata;
      logic [SFR_DATA_W-1:0] rdata;
   } sfr_txn_t;

   localparam int unsigned SFR_TXN_W = $bits(sfr_txn_t);

   function automatic sfr_txn_t make_txn(input logic                  err,
                                         input logic                  we,
                                         input logic [SFR_ADDR_W-1:0] addr,
                                         input logic [SFR_DATA_W-1:0] wdata,
                                         input logic [SFR_DATA_W-1:0] rdata);
      sfr_txn_t t;
      t.err   = err;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      t.rdata = rdata;
      return t;
   endfunction

endpackage

// File: rtl/sfr_txn_fifo.sv
// Synchronous FIFO whose head entry, flags and level all come straight from flops.
module sfr_txn_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [LVL_W-1:0] kept;
   logic [WIDTH-1:0] head_q, head_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   // A push into a full FIFO is only accepted when the head leaves the same cycle.
   always_comb begin
      do_pop   = pop & ~empty_q;
      do_push  = push & (~full_q | do_pop);
      kept     = level_q - LVL_W'(do_pop);
      level_d  = kept + LVL_W'(do_push);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
      end
      if (level_d == '0) begin
         head_d = '0;
      end else if (kept == '0) begin
         head_d = push_data;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
      full_d  = (level_d == LVL_W'(DEPTH));
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset: pointers and level decide what is visible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = head_q;
   assign full  = full_q;
   assign empty = empty_q;
   assign level = level_q;

endmodule

// File: rtl/sfr_bus_capture.sv
// Passive SFR bus capture: packs strobed cycles into records, aligns read data, buffers and streams them.
module sfr_bus_capture
   import sfr_mon_pkg::*;
#(
   parameter int unsigned ADDR_W = SFR_ADDR_W,
   parameter int unsigned DATA_W = SFR_DATA_W,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned RD_LAT = 0,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [ADDR_W-1:0]      address,
   input  logic [DATA_W-1:0]      write_data,
   input  logic [DATA_W-1:0]      read_data,
   input  logic                   we,
   input  logic                   re,
   output logic                   txn_valid,
   input  logic                   txn_ready,
   output sfr_txn_t               txn_rec,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   overflow,
   output logic [CNT_W-1:0]       drop_cnt
);

   logic                 cap;
   sfr_txn_t             cap_rec;
   logic                 push;
   sfr_txn_t             push_rec;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 drop;
   logic                 ovf_q, ovf_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SFR_DATA_W-1:0] rd_now;

   // Record skeleton; rdata is filled in once the read data is valid.
   always_comb begin
      cap     = enable & (we | re);
      rd_now  = SFR_DATA_W'(read_data);
      cap_rec = make_txn(we & re, we, SFR_ADDR_W'(address),
                         we ? SFR_DATA_W'(write_data) : '0, '0);
   end

   if (RD_LAT == 0) begin : g_lat0
      always_comb begin
         push           = cap;
         push_rec       = cap_rec;
         push_rec.rdata = re ? rd_now : '0;
      end
   end else begin : g_lat1
      logic     stg_vld_q, stg_vld_d;
      logic     stg_re_q, stg_re_d;
      sfr_txn_t stg_rec_q, stg_rec_d;

      // Every record goes through the stage so reads and writes stay in bus order.
      always_comb begin
         stg_vld_d      = cap;
         stg_re_d       = re;
         stg_rec_d      = cap_rec;
         push           = stg_vld_q;
         push_rec       = stg_rec_q;
         push_rec.rdata = stg_re_q ? rd_now : '0;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            stg_vld_q <= 1'b0;
            stg_re_q  <= 1'b0;
            stg_rec_q <= '0;
         end else begin
            stg_vld_q <= stg_vld_d;
            stg_re_q  <= stg_re_d;
            stg_rec_q <= stg_rec_d;
         end
      end
   end

   sfr_txn_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SFR_TXN_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_rec),
      .pop       (txn_ready),
      .head      (txn_rec),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // A full FIFO with no pop this cycle loses the incoming record.
   always_comb begin
      drop  = push & fifo_full & ~txn_ready;
      ovf_d = ovf_q | drop;
      cnt_d = cnt_q;
      if (drop && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         cnt_q <= cnt_d;
      end
   end

   assign txn_valid = ~fifo_empty;
   assign overflow  = ovf_q;
   assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_sfr_bus_capture.sv
// Bench for sfr_bus_capture: RD_LAT=0 and RD_LAT=1 instances on one bus, checked against a queue model.
module tb_sfr_bus_capture;
   import sfr_mon_pkg::*;

   localparam int DEPTH = 8;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] address;
   logic [7:0] write_data;
   logic [7:0] read_data;
   logic       we;
   logic       re;
   logic       txn_ready;

   logic       v0, v1, ovf0, ovf1;
   sfr_txn_t   rec0, rec1;
   logic [3:0] lvl0, lvl1;
   logic [15:0] cnt0;
   logic [2:0]  cnt1;

   logic       dv   [2];
   sfr_txn_t   drec [2];
   logic [3:0] dlvl [2];
   logic       dovf [2];
   int         dcnt [2];

   sfr_txn_t   mq [2][$];
   bit         pend_v  [2];
   bit         pend_re [2];
   sfr_txn_t   pend_r  [2];
   bit         m_ovf   [2];
   int         m_cnt   [2];
   int         cnt_max [2] = '{65535, 7};

   int n_cmp = 0;
   int n_bad = 0;

   sfr_bus_capture #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(0), .CNT_W(16)) u_lat0 (
      .clk(clk), .reset(reset), .enable(enable), .address(address),
      .write_data(write_data), .read_data(read_data), .we(we), .re(re),
      .txn_valid(v0), .txn_ready(txn_ready), .txn_rec(rec0),
      .fifo_level(lvl0), .overflow(ovf0), .drop_cnt(cnt0));

   sfr_bus_capture #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(1), .CNT_W(3)) u_lat1 (
      .clk(clk), .reset(reset), .enable(enable), .address(address),
      .write_data(write_data), .read_data(read_data), .we(we), .re(re),
      .txn_valid(v1), .txn_ready(txn_ready), .txn_rec(rec1),
      .fifo_level(lvl1), .overflow(ovf1), .drop_cnt(cnt1));

   always_comb begin
      dv[0] = v0;     dv[1] = v1;
      drec[0] = rec0; drec[1] = rec1;
      dlvl[0] = lvl0; dlvl[1] = lvl1;
      dovf[0] = ovf0; dovf[1] = ovf1;
      dcnt[0] = 32'(cnt0);
      dcnt[1] = 32'(cnt1);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic sfr_txn_t rec_of(bit err, bit w, logic [7:0] a, logic [7:0] wd, logic [7:0] rd);
      sfr_txn_t t;
      t = '{err: err, we: w, addr: a, wdata: wd, rdata: rd};
      return t;
   endfunction

   // Reference behaviour: a bounded queue per instance, plus a one-deep delay for RD_LAT=1.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         sfr_txn_t r, p;
         bit       do_push, do_pop, was_full, cap;
         if (reset) begin
            mq[i].delete();
            pend_v[i] = 0;
            pend_re[i] = 0;
            m_ovf[i] = 0;
            m_cnt[i] = 0;
            continue;
         end
         cap = enable && (we || re);
         r = rec_of(we && re, we, address, we ? write_data : 8'h00, 8'h00);
         if (i == 0) begin
            do_push = cap;
            p = r;
            if (re) p.rdata = read_data;
         end else begin
            do_push = pend_v[i];
            p = pend_r[i];
            if (pend_re[i]) p.rdata = read_data;
            pend_v[i]  = cap;
            pend_r[i]  = r;
            pend_re[i] = re;
         end
         do_pop   = (mq[i].size() > 0) && txn_ready;
         was_full = (mq[i].size() == DEPTH);
         if (do_pop) void'(mq[i].pop_front());
         if (do_push) begin
            if (was_full && !do_pop) begin
               m_ovf[i] = 1;
               if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
            end else begin
               mq[i].push_back(p);
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_bus(bit en, bit w, bit r, logic [7:0] a, logic [7:0] wd, logic [7:0] rd);
      enable = en; we = w; re = r; address = a; write_data = wd; read_data = rd;
   endtask

   task automatic idle();
      set_bus(1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic do_reset();
      reset = 1;
      idle();
      cycle();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      txn_ready = 0;
      set_bus(1, 1, 1, 8'h55, 8'h66, 8'h77);
      cycle();
      cycle();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (dv[i] !== 1'b0 || drec[i] !== '0 || dlvl[i] !== 4'd0 || dovf[i] !== 1'b0 || dcnt[i] !== 0) begin
            n_bad++;
            $display("FAIL reset[%0d]: valid %b lvl %0d ovf %b cnt %0d rec %h, want all zero",
                     i, dv[i], dlvl[i], dovf[i], dcnt[i], drec[i]);
         end
      end
      reset = 0;
      idle();
   endtask

   task automatic test_write_lat0();
      sfr_txn_t exp;
      exp = rec_of(0, 1, 8'h12, 8'hA5, 8'h00);
      txn_ready = 1;
      set_bus(1, 1, 0, 8'h12, 8'hA5, 8'hEE);
      cycle();
      idle();
      n_cmp++;
      if (dv[0] !== 1'b1 || drec[0] !== exp) begin
         n_bad++;
         $display("FAIL write_lat0: valid %b rec %h, want 1 %h", dv[0], drec[0], exp);
      end
      n_cmp++;
      if (dv[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL write_lat1_early: valid %b, want 0", dv[1]);
      end
      cycle();
      n_cmp++;
      if (dv[1] !== 1'b1 || drec[1] !== exp || dv[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL write_lat1: valid %b rec %h lat0 valid %b, want 1 %h 0", dv[1], drec[1], dv[0], exp);
      end
      cycle();
   endtask

   task automatic test_read_lat1();
      sfr_txn_t e0, e1;
      e0 = rec_of(0, 0, 8'h34, 8'h00, 8'h11);
      e1 = rec_of(0, 0, 8'h34, 8'h00, 8'h5C);
      txn_ready = 1;
      set_bus(1, 0, 1, 8'h34, 8'hC3, 8'h11);
      cycle();
      set_bus(1, 0, 0, 8'h00, 8'h00, 8'h5C);
      n_cmp++;
      if (dv[0] !== 1'b1 || drec[0] !== e0 || dv[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL read_lat0: valid %b rec %h lat1 valid %b, want 1 %h 0", dv[0], drec[0], dv[1], e0);
      end
      cycle();
      idle();
      n_cmp++;
      if (dv[1] !== 1'b1 || drec[1] !== e1) begin
         n_bad++;
         $display("FAIL read_lat1: valid %b rec %h, want 1 %h", dv[1], drec[1], e1);
      end
      cycle();
   endtask

   task automatic test_overflow();
      logic [7:0] a_arr [10];
      logic [7:0] d_arr [10];
      sfr_txn_t   exp;
      do_reset();
      txn_ready = 0;
      for (int k = 0; k < 10; k++) begin
         a_arr[k] = 8'($urandom);
         d_arr[k] = 8'($urandom);
         set_bus(1, 1, 0, a_arr[k], d_arr[k], 8'($urandom));
         cycle();
      end
      idle();
      cycle();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (dlvl[i] !== 4'd8 || dovf[i] !== 1'b1 || dcnt[i] !== 2) begin
            n_bad++;
            $display("FAIL overflow[%0d]: lvl %0d ovf %b cnt %0d, want 8 1 2", i, dlvl[i], dovf[i], dcnt[i]);
         end
      end
      txn_ready = 1;
      for (int k = 0; k < 8; k++) begin
         exp = rec_of(0, 1, a_arr[k], d_arr[k], 8'h00);
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dv[i] !== 1'b1 || drec[i] !== exp) begin
               n_bad++;
               $display("FAIL drain[%0d] #%0d: valid %b rec %h, want 1 %h", i, k, dv[i], drec[i], exp);
            end
         end
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (dv[i] !== 1'b0 || dlvl[i] !== 4'd0 || dovf[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL drained[%0d]: valid %b lvl %0d ovf %b, want 0 0 1", i, dv[i], dlvl[i], dovf[i]);
         end
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      txn_ready = 0;
      for (int k = 0; k < 9; k++) begin
         set_bus(1, 1, 0, 8'(k), 8'($urandom), 8'h00);
         cycle();
      end
      n_cmp++;
      if (dlvl[0] !== 4'd8 || dcnt[0] !== 1 || dlvl[1] !== 4'd8 || dcnt[1] !== 0) begin
         n_bad++;
         $display("FAIL fill: lvl %0d/%0d cnt %0d/%0d, want 8/8 1/0", dlvl[0], dlvl[1], dcnt[0], dcnt[1]);
      end
      txn_ready = 1;
      set_bus(1, 1, 0, 8'h09, 8'($urandom), 8'h00);
      cycle();
      n_cmp++;
      if (dlvl[0] !== 4'd8 || dcnt[0] !== 1 || dlvl[1] !== 4'd8 || dcnt[1] !== 0 ||
          drec[0].addr !== 8'h01 || drec[1].addr !== 8'h01) begin
         n_bad++;
         $display("FAIL full_push_pop: lvl %0d/%0d cnt %0d/%0d head %h/%h, want 8/8 1/0 01/01",
                  dlvl[0], dlvl[1], dcnt[0], dcnt[1], drec[0].addr, drec[1].addr);
      end
      txn_ready = 0;
      idle();
      cycle();
      n_cmp++;
      if (dlvl[1] !== 4'd8 || dcnt[1] !== 1 || dcnt[0] !== 1) begin
         n_bad++;
         $display("FAIL full_stage_drop: lvl1 %0d cnt %0d/%0d, want 8 1/1", dlvl[1], dcnt[0], dcnt[1]);
      end
   endtask

   task automatic test_err();
      sfr_txn_t e_err0, e_err1, e_wr;
      do_reset();
      txn_ready = 1;
      e_err0 = rec_of(1, 1, 8'h7F, 8'h3C, 8'h66);
      e_err1 = rec_of(1, 1, 8'h7F, 8'h3C, 8'h77);
      e_wr   = rec_of(0, 1, 8'h20, 8'h99, 8'h00);
      set_bus(1, 1, 1, 8'h7F, 8'h3C, 8'h66);
      cycle();
      set_bus(1, 1, 0, 8'h20, 8'h99, 8'h77);
      n_cmp++;
      if (dv[0] !== 1'b1 || drec[0] !== e_err0) begin
         n_bad++;
         $display("FAIL err_lat0: valid %b rec %h, want 1 %h", dv[0], drec[0], e_err0);
      end
      cycle();
      idle();
      n_cmp++;
      if (drec[0] !== e_wr || dv[1] !== 1'b1 || drec[1] !== e_err1) begin
         n_bad++;
         $display("FAIL err_next: rec0 %h rec1 %h valid1 %b, want %h %h 1", drec[0], drec[1], dv[1], e_wr, e_err1);
      end
      cycle();
      n_cmp++;
      if (dv[1] !== 1'b1 || drec[1] !== e_wr || dv[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL err_lat1_next: valid %b rec %h lat0 valid %b, want 1 %h 0", dv[1], drec[1], dv[0], e_wr);
      end
      cycle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      txn_ready = 0;
      for (int k = 0; k < 4; k++) begin
         set_bus(1, k < 3, k == 3, 8'($urandom), 8'($urandom), 8'($urandom));
         cycle();
      end
      reset = 1;
      set_bus(1, 1, 0, 8'h44, 8'h55, 8'h66);
      cycle();
      reset = 0;
      idle();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (dv[i] !== 1'b0 || dlvl[i] !== 4'd0 || dovf[i] !== 1'b0 || drec[i] !== '0) begin
            n_bad++;
            $display("FAIL reset_mid[%0d]: valid %b lvl %0d ovf %b rec %h, want 0 0 0 0",
                     i, dv[i], dlvl[i], dovf[i], drec[i]);
         end
      end
      for (int c = 0; c < 3; c++) begin
         cycle();
         n_cmp++;
         if (dv[0] !== 1'b0 || dv[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL stale[%0d]: valid %b/%b, want 0/0", c, dv[0], dv[1]);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      txn_ready = 0;
      for (int k = 0; k < 20; k++) begin
         set_bus(1, 1, 0, 8'($urandom), 8'($urandom), 8'h00);
         cycle();
      end
      idle();
      cycle();
      n_cmp++;
      if (dcnt[0] !== 12 || dcnt[1] !== 7 || dovf[0] !== 1'b1 || dovf[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL saturate: cnt %0d/%0d ovf %b/%b, want 12/7 1/1", dcnt[0], dcnt[1], dovf[0], dovf[1]);
      end
   endtask

   task automatic test_random();
      bit exp_v;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         txn_ready = ($urandom_range(99) < 45);
         set_bus($urandom_range(99) < 85, $urandom_range(1), $urandom_range(1),
                 8'($urandom), 8'($urandom), 8'($urandom));
         if (c == 400) reset = 1;
         cycle();
         reset = 0;
         for (int i = 0; i < 2; i++) begin
            exp_v = (mq[i].size() > 0);
            n_cmp++;
            if (dv[i] !== exp_v || dlvl[i] !== 4'(mq[i].size()) || dovf[i] !== m_ovf[i] ||
                dcnt[i] !== m_cnt[i] || (exp_v && drec[i] !== mq[i][0])) begin
               n_bad++;
               $display("FAIL random[%0d] cyc %0d: valid %b/%b lvl %0d/%0d ovf %b/%b cnt %0d/%0d rec %h/%h",
                        i, c, dv[i], exp_v, dlvl[i], mq[i].size(), dovf[i], m_ovf[i],
                        dcnt[i], m_cnt[i], drec[i], exp_v ? mq[i][0] : '0);
            end
         end
      end
   endtask

   initial begin
      reset = 1;
      txn_ready = 0;
      set_bus(0, 0, 0, 8'h00, 8'h00, 8'h00);
      test_reset();
      test_write_lat0();
      test_read_lat1();
      test_overflow();
      test_full_push_pop();
      test_err();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
